// File: rtl/attn_pkg.sv
// attn_pkg: shared sizes, index width and FSM encoding for the attention score controller
package attn_pkg;
    localparam int SEQ_LEN = 30;
    localparam int D_MODEL = 16;
    localparam int N_HEAD  = 4;
    localparam int IDX_W   = 5;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WRITE, DONE} state_t;

    function automatic logic [IDX_W-1:0] last_idx(input int seq_len);
        return IDX_W'(seq_len - 1);
    endfunction
endpackage

// File: rtl/attn_score_ctrl_if.sv
// attn_score_ctrl_if: query memory, score engine and result row buses
interface attn_score_ctrl_if #(
    parameter int SEQ_LEN = attn_pkg::SEQ_LEN,
    parameter int D_MODEL = attn_pkg::D_MODEL,
    parameter int N_HEAD  = attn_pkg::N_HEAD
);
    import attn_pkg::*;
    logic                      q_rd_en;
    logic [IDX_W-1:0]          q_rd_addr;
    logic [D_MODEL-1:0]        q_rd_data;
    logic [D_MODEL-1:0]        eng_query;
    logic                      eng_valid;
    logic [SEQ_LEN-1:0]        eng_score_1;
    logic [SEQ_LEN-1:0]        eng_score_2;
    logic [SEQ_LEN-1:0]        eng_score_3;
    logic [SEQ_LEN-1:0]        eng_score_4;
    logic                      row_valid;
    logic                      row_ready;
    logic [IDX_W-1:0]          row_addr;
    logic [N_HEAD*SEQ_LEN-1:0] row_data;

    modport master (
        output q_rd_en, q_rd_addr, eng_query, eng_valid, row_valid, row_addr, row_data,
        input  q_rd_data, eng_score_1, eng_score_2, eng_score_3, eng_score_4, row_ready
    );
    modport slave (
        input  q_rd_en, q_rd_addr, eng_query, eng_valid, row_valid, row_addr, row_data,
        output q_rd_data, eng_score_1, eng_score_2, eng_score_3, eng_score_4, row_ready
    );
endinterface

// File: rtl/attn_row_reg.sv
// attn_row_reg: result row holding register, stable until the valid/ready handshake
module attn_row_reg #(
    parameter int W  = 120,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clr,
    input  logic          ready,
    input  logic [W-1:0]  d,
    input  logic [AW-1:0] a,
    output logic          valid,
    output logic [W-1:0]  data,
    output logic [AW-1:0] addr,
    output logic          fire
);
    assign fire = valid && ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
            addr  <= a;
        end else if (fire) begin
            valid <= 1'b0;
        end
endmodule

// File: rtl/attn_score_ctrl.sv
// attn_score_ctrl: sequences query fetch, score engine issue and row write-out over a pass
module attn_score_ctrl #(
    parameter int SEQ_LEN = attn_pkg::SEQ_LEN,
    parameter int D_MODEL = attn_pkg::D_MODEL,
    parameter int N_HEAD  = attn_pkg::N_HEAD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    attn_score_ctrl_if.master bus
);
    import attn_pkg::*;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [D_MODEL-1:0] query;
    logic               fire;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            query         <= '0;
            bus.q_rd_en   <= 1'b0;
            bus.eng_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            bus.q_rd_en   <= 1'b0;
            bus.eng_valid <= 1'b0;
            done          <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE:
                        if (start) begin
                            state       <= FETCH;
                            idx         <= '0;
                            bus.q_rd_en <= 1'b1;
                            busy        <= 1'b1;
                        end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        query         <= bus.q_rd_data;
                        bus.eng_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                    ISSUE: state <= WRITE;
                    WRITE:
                        if (fire) begin
                            if (idx == last_idx(SEQ_LEN)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                idx         <= idx + 1'b1;
                                state       <= FETCH;
                                bus.q_rd_en <= 1'b1;
                            end
                        end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

    // outputs are forced to zero outside their own state so the engine and memory see clean idles
    assign bus.q_rd_addr = bus.q_rd_en ? idx : '0;
    assign bus.eng_query = bus.eng_valid ? query : '0;

    attn_row_reg #(.W(N_HEAD*SEQ_LEN), .AW(IDX_W)) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ISSUE && !abort),
        .clr   (abort),
        .ready (bus.row_ready),
        .d     ({bus.eng_score_4, bus.eng_score_3, bus.eng_score_2, bus.eng_score_1}),
        .a     (idx),
        .valid (bus.row_valid),
        .data  (bus.row_data),
        .addr  (bus.row_addr),
        .fire  (fire)
    );
endmodule

// File: tb/tb_attn_score_ctrl.sv
// tb_attn_score_ctrl: table-driven passes, random back-pressure and hand-written abort/reset/start sequences
module tb_attn_score_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] mem [32];

    attn_score_ctrl_if bus ();
    attn_score_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.q_rd_en) bus.q_rd_data <= mem[bus.q_rd_addr];

    // engine stub: head h scores are the low query byte, inverted for odd h
    assign bus.eng_score_1 = bus.eng_valid ? ~30'(bus.eng_query[7:0]) : '0;
    assign bus.eng_score_2 = bus.eng_valid ?  30'(bus.eng_query[7:0]) : '0;
    assign bus.eng_score_3 = bus.eng_valid ? ~30'(bus.eng_query[7:0]) : '0;
    assign bus.eng_score_4 = bus.eng_valid ?  30'(bus.eng_query[7:0]) : '0;

    function automatic logic [119:0] exp_row(input logic [15:0] q);
        logic [29:0] b;
        b = 30'(q[7:0]);
        return {b, ~b, b, ~b};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 32; i++) mem[i] = rnd ? 16'($urandom) : 16'(i * 16'h0101);
    endtask

    typedef struct {
        int stall_row;
        int stall_len;
        int abort_row;
        bit rnd;
        int exp_done;
        int exp_rows;
    } vec_t;

    task automatic run_pass(input vec_t v);
        int cyc = 0, nrow = 0, nfetch = 0, niss = 0, stalled = 0, scnt = 0, done_cyc = -1, ndone = 0;
        bit prev_stall = 0, aborted = 0;
        logic [119:0] held_d;
        logic [4:0]   held_a;
        @(negedge clk);
        start = 1'b1;
        bus.row_ready = 1'b1;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (aborted) begin
                chk("abort_idle", {busy, bus.row_valid, bus.q_rd_en, bus.eng_valid, done}, 0);
                break;
            end
            if (bus.q_rd_en) begin
                chk("fetch_addr", bus.q_rd_addr, nfetch);
                nfetch++;
            end
            if (bus.eng_valid) begin
                chk("eng_query", bus.eng_query, mem[niss]);
                if (niss == v.abort_row) begin
                    abort = 1'b1;
                    aborted = 1;
                end
                niss++;
            end else chk("eng_query_zero", bus.eng_query, 0);
            if (v.rnd) bus.row_ready = ($urandom_range(0, 3) != 0);
            else bus.row_ready = !(bus.row_valid && bus.row_addr == 5'(v.stall_row) && scnt < v.stall_len);
            if (bus.row_valid) begin
                chk("no_mem_eng_in_write", {bus.q_rd_en, bus.eng_valid}, 0);
                if (prev_stall) chk("stall_stable", {held_a, held_d}, {bus.row_addr, bus.row_data});
                if (!bus.row_ready) begin
                    scnt++;
                    stalled++;
                end else if (!aborted) begin
                    chk("row_addr", bus.row_addr, nrow);
                    chk("row_data", bus.row_data, exp_row(mem[nrow]));
                    nrow++;
                end
                prev_stall = !bus.row_ready;
                held_d = bus.row_data;
                held_a = bus.row_addr;
            end else prev_stall = 0;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                chk("busy_in_done", busy, 1);
            end
            if (!busy) break;
        end
        if (cyc >= 600) chk("pass_timeout", cyc, 0);
        if (done_cyc >= 0) chk("busy_low_cycle", cyc, done_cyc + 1);
        chk("done_cycle", done_cyc, v.exp_done == 0 ? 121 + stalled : v.exp_done);
        chk("done_count", ndone, v.exp_done < 0 ? 0 : 1);
        chk("row_count", nrow, v.exp_rows);
        bus.row_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("quiet_after_pass", {busy, done, bus.row_valid, bus.q_rd_en}, 0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int cyc, ndone, n;
        vecs[0] = '{-1, 0, -1, 0, 121, 30};
        vecs[1] = '{ 7, 5, -1, 0, 126, 30};
        vecs[2] = '{ 0, 3, -1, 0, 124, 30};
        vecs[3] = '{29, 2, -1, 0, 123, 30};
        vecs[4] = '{-1, 0, 12, 0,  -1, 12};
        vecs[5] = '{-1, 0, -1, 1,   0, 30};
        vecs[6] = '{-1, 0, -1, 1,   0, 30};
        bus.row_ready = 1'b1;
        fill_mem(0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, bus.q_rd_en, bus.q_rd_addr, bus.eng_valid, bus.eng_query,
                              bus.row_valid, bus.row_addr, bus.row_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, bus.q_rd_en}, 0);

        for (int i = 0; i < 7; i++) begin
            fill_mem(vecs[i].rnd);
            run_pass(vecs[i]);
        end

        // start held high: one pass, next pass fetches row 0 two cycles after done
        fill_mem(0);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        ndone = 0;
        while (cyc < 123) begin
            @(negedge clk);
            cyc++;
            if (done) ndone++;
            if (cyc == 121) chk("hold_done_cycle", done, 1);
            if (cyc == 122) chk("hold_idle_gap", {busy, bus.q_rd_en}, 0);
        end
        chk("hold_one_done", ndone, 1);
        chk("hold_restart_fetch", {busy, bus.q_rd_en, bus.q_rd_addr}, {1'b1, 1'b1, 5'd0});
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("hold_abort_idle", {busy, bus.q_rd_en}, 0);

        // asynchronous reset while row 20 waits in WRITE
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!(bus.row_valid && bus.row_addr == 5'd20) && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk("reach_row20", n < 200, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, done, bus.q_rd_en, bus.q_rd_addr, bus.eng_valid, bus.eng_query,
                                    bus.row_valid, bus.row_addr, bus.row_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (150) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("no_activity_after_reset", ndone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/attn_score_ctrl.md
ATTN_SCORE_CTRL -- requirements
Module: attn_score_ctrl

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 30, number of query rows per pass.
REQ-002 SHALL have parameter D_MODEL, default 16, query width in bits (4 heads x 4 bits).
REQ-003 SHALL have parameter N_HEAD, default 4, number of score heads.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a pass; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a pass in progress.
REQ-008 q_rd_en  output  1  query memory read strobe.
REQ-009 q_rd_addr  output  5  query row index.
REQ-010 q_rd_data  input  D_MODEL  query row, valid the cycle after q_rd_en.
REQ-011 eng_query  output  D_MODEL  query word to score engine.
REQ-012 eng_valid  output  1  score engine input valid.
REQ-013 eng_score_1..eng_score_4  input  SEQ_LEN each  per-head binary score rows, combinational response to eng_query/eng_valid in the same cycle.
REQ-014 row_valid  output  1  result row available.
REQ-015 row_ready  input  1  downstream accepts row.
REQ-016 row_addr  output  5  index of row on row_data.
REQ-017 row_data  output  N_HEAD*SEQ_LEN  {score_4, score_3, score_2, score_1}, head 1 in LSBs.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on pass completion.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, LOAD, ISSUE, WRITE, DONE.
REQ-021 IDLE: start=1 -> FETCH, row index idx cleared to 0; start outside IDLE ignored.
REQ-022 FETCH: q_rd_en=1, q_rd_addr=idx for exactly one cycle -> LOAD.
REQ-023 LOAD: q_rd_data captured into query register -> ISSUE.
REQ-024 ISSUE: eng_valid=1, eng_query=query register for exactly one cycle; eng_score_1..4 registered into row_data at end of this cycle -> WRITE.
REQ-025 eng_valid SHALL be 0 and eng_query SHALL be 0 in every state except ISSUE.
REQ-026 WRITE: row_valid=1, row_addr=idx; row_data and row_addr held stable until row_valid&&row_ready.
REQ-027 On WRITE handshake: idx==SEQ_LEN-1 -> DONE; else idx+1 -> FETCH.
REQ-028 DONE: done=1 for one cycle -> IDLE; busy=1 in DONE.
REQ-029 Latency with row_ready tied 1: 4 cycles per row; done high in cycle SEQ_LEN*4+1 after the edge sampling start (cycle 121 for default).
REQ-030 row_ready low SHALL stall only WRITE; no engine or memory activity while stalled.
REQ-031 abort=1 in any state SHALL force IDLE next cycle with row_valid, q_rd_en, eng_valid deasserted and no done pulse; abort has priority over start and handshake.
REQ-032 idx SHALL never exceed SEQ_LEN-1; no wrap to 0 within a pass.

Reset
REQ-033 Reset SHALL force IDLE, idx=0, query register=0, row_data=0, and all outputs 0.
REQ-034 Reset mid-pass SHALL discard the pass; no done pulse after release until a new start.

Structure
REQ-035 SEQ_LEN, D_MODEL, N_HEAD, index width and FSM state encoding SHALL live in shared package attn_pkg.
REQ-036 Block SHALL be self-contained; the score engine is instantiated by the parent, not inside this block.
REQ-037 One optional sub-module attn_row_reg (row_data/row_addr holding register with valid/ready) is natural.

Verification
REQ-038 start pulse, row_ready=1, query mem row i = i*0x0101 -> 30 FETCH reads addr 0..29, 30 eng_valid pulses, 30 rows addr 0..29, done at cycle 121, busy low at cycle 122.
REQ-039 Engine model returns eng_score_h = {30{h[0]}} ^ idx -> row_data per row matches {s4,s3,s2,s1} exactly, head 1 in bits [29:0].
REQ-040 row_ready low 5 cycles on row 7 -> row_data/row_addr=7 stable all 5 cycles, no q_rd_en/eng_valid during stall, done delayed by 5 cycles.
REQ-041 abort asserted during ISSUE of row 12 -> IDLE next cycle, no further row_valid, no done; new start restarts at addr 0.
REQ-042 start held high throughout pass -> only one pass; second pass begins the cycle after DONE returns to IDLE.
REQ-043 rst_n low during WRITE of row 20 -> all outputs 0 immediately, no done after release.
